// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address types for the register file
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_NUM_READ   = 2;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

  // Hard-wired zero register.
  localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - enabled D flip-flop bank with asynchronous active-low clear
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, clears q
//   en   : load enable
//   d    : next value
//   q    : stored value
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q_q <= '0;
    else if (en) q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard with reservation count
//   clk, rst    : clock and asynchronous active-low reset
//   iss_valid   : reserve iss_addr when iss_ready
//   iss_addr    : destination to reserve
//   iss_ready   : destination is free (or x0)
//   wr_en       : writeback strobe, releases wr_addr
//   wr_addr     : writeback destination
//   flush       : drop every reservation
//   busy        : per-register busy vector (bit 0 always 0)
//   pending_cnt : number of reserved registers
module regfile_scoreboard import regfile_pkg::*; #(
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int ADDR_WIDTH = $clog2(NUM_REGS),
  localparam int CNT_WIDTH  = $clog2(NUM_REGS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  output logic                  iss_ready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy,
  output logic [CNT_WIDTH-1:0]  pending_cnt
);

  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 iss_set;
  logic                 wb_clr;

  // No look-ahead on a same-cycle writeback: a busy destination stalls
  // until the release is visible in busy_q.
  assign iss_ready = (iss_addr == '0) || !busy_q[iss_addr];

  assign iss_set = iss_valid && iss_ready && (iss_addr != '0) && !flush;
  assign wb_clr  = wr_en && (wr_addr != '0) && busy_q[wr_addr];

  // iss_set implies iss_addr is free while wb_clr implies wr_addr is busy,
  // so the two never target the same register in one cycle.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr)  busy_d[wr_addr]  = 1'b0;
    if (iss_set) busy_d[iss_addr] = 1'b1;
    if (flush)   busy_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q + CNT_WIDTH'(iss_set) - CNT_WIDTH'(wb_clr);
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with busy-bit scoreboard
//   Optional feature macro: RF_BYPASS_EN (same-cycle writeback forwarding)
//   clk, rst    : clock and asynchronous active-low reset
//   rd_addr     : NUM_READ packed read addresses
//   rd_data     : NUM_READ packed read data
//   rd_busy     : per-port source-busy flag
//   iss_valid/iss_addr/iss_ready : destination reservation handshake
//   wr_en/wr_addr/wr_data        : writeback port
//   flush       : clear all reservations
//   pending_cnt : number of reserved registers
module regfile_sb import regfile_pkg::*; #(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int NUM_READ   = DEF_NUM_READ,
  parameter  int ADDR_WIDTH = $clog2(NUM_REGS),
  localparam int CNT_WIDTH  = $clog2(NUM_REGS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           iss_valid,
  input  logic [ADDR_WIDTH-1:0]          iss_addr,
  output logic                           iss_ready,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           flush,
  output logic [CNT_WIDTH-1:0]           pending_cnt
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  regfile_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_addr    (iss_addr),
    .iss_ready   (iss_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .flush       (flush),
    .busy        (busy),
    .pending_cnt (pending_cnt)
  );

  // x0 has no storage; every other register loads on a decoded write hit.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign regs[r] = '0;
    end else begin : g_store
      dff #(.WIDTH(DATA_WIDTH)) u_dff (
        .clk (clk),
        .rst (rst),
        .en  (wr_en && (wr_addr == ADDR_WIDTH'(r))),
        .d   (wr_data),
        .q   (regs[r])
      );
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    a       = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      a = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[a];
      rd_busy[p]                          = busy[a];
`ifdef RF_BYPASS_EN
      if (wr_en && (wr_addr == a) && (a != '0)) begin
        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data;
        rd_busy[p]                          = 1'b0;
      end
`endif
    end
  end

endmodule
